// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT FIFO link: FSM encodings, line levels
// and the parity helper used by both serializer and deserializer.
package usrt_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity over a zero-extended word (unused upper bits must be 0).
  function automatic logic even_parity16(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/usrt_fifo.sv
// Synchronous first-word fall-through FIFO with extra-MSB pointers.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module usrt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_pop_ok;
  logic          w_push_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance and storage write; pointers wrap modulo 2*DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usrt_fifo_link.sv
// USRT link: TX FIFO -> serializer -> SO, and (SI or SO loopback) ->
// deserializer -> RX FIFO, with sticky overrun/parity/frame flags.
module usrt_fifo_link
  import usrt_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [DATA_W-1:0] Tx_Data,
  input  logic              SEND,
  input  logic              READ,
  input  logic              LOOP,
  input  logic              SI,
  input  logic              clr_err,
  output logic              SO,
  output logic [DATA_W-1:0] Rx_Data,
  output logic              NINTO,
  output logic              NINTI,
  output logic              tx_full,
  output logic              rx_overrun,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // FIFO wiring
  logic [DATA_W-1:0] w_tx_head;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_pop;
  logic              w_rx_push;
  logic              w_rx_full;
  logic              w_rx_empty;

  // Serializer state
  tx_state_e         r_tx_state, w_tx_state_nx;
  logic [CNT_W-1:0]  r_tx_cnt, w_tx_cnt_nx;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nx;
  logic              r_tx_par, w_tx_par_nx;
  logic              r_so, w_so_nx;
  logic [15:0]       w_tx_ext;

  // Deserializer state
  rx_state_e         r_rx_state, w_rx_state_nx;
  logic [CNT_W-1:0]  r_rx_cnt, w_rx_cnt_nx;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nx;
  logic [15:0]       w_rx_ext;
  logic              w_rx_line;
  logic              w_par_set;
  logic              w_frame_set;
  logic              w_ovr_set;

  // Sticky flags
  logic r_rx_overrun;
  logic r_parity_err;
  logic r_frame_err;

  usrt_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_push  (load),
    .i_data  (Tx_Data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  usrt_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (READ),
    .o_data  (Rx_Data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign w_rx_line = LOOP ? r_so : SI;

  // Zero-extend the words fed to the parity helper.
  always_comb begin
    w_tx_ext = '0;
    w_rx_ext = '0;
    w_tx_ext[DATA_W-1:0] = w_tx_head;
    w_rx_ext[DATA_W-1:0] = r_rx_shift;
  end

  // Serializer next state: SO is registered and always carries the bit of
  // the state being entered, so the start bit appears right after the pop.
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_shift_nx = r_tx_shift;
    w_tx_par_nx   = r_tx_par;
    w_so_nx       = r_so;
    w_tx_pop      = 1'b0;
    case (r_tx_state)
      TX_IDLE, TX_STOP: begin
        if (SEND && !w_tx_empty) begin
          w_tx_state_nx = TX_START;
          w_so_nx       = START_BIT;
          w_tx_pop      = 1'b1;
          w_tx_shift_nx = w_tx_head;
          w_tx_par_nx   = even_parity16(w_tx_ext);
        end else begin
          w_tx_state_nx = TX_IDLE;
          w_so_nx       = STOP_BIT;
        end
      end
      TX_START: begin
        w_tx_state_nx = TX_DATA;
        w_tx_cnt_nx   = '0;
        w_so_nx       = r_tx_shift[0];
        w_tx_shift_nx = r_tx_shift >> 1;
      end
      TX_DATA: begin
        if (r_tx_cnt == CNT_LAST) begin
          if (PARITY_EN != 0) begin
            w_tx_state_nx = TX_PARITY;
            w_so_nx       = r_tx_par;
          end else begin
            w_tx_state_nx = TX_STOP;
            w_so_nx       = STOP_BIT;
          end
        end else begin
          w_tx_cnt_nx   = r_tx_cnt + 1'b1;
          w_so_nx       = r_tx_shift[0];
          w_tx_shift_nx = r_tx_shift >> 1;
        end
      end
      TX_PARITY: begin
        w_tx_state_nx = TX_STOP;
        w_so_nx       = STOP_BIT;
      end
      default: begin
        w_tx_state_nx = TX_IDLE;
        w_so_nx       = STOP_BIT;
      end
    endcase
  end

  // Serializer state register; reset forces the line back to idle high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_so       <= STOP_BIT;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_shift <= w_tx_shift_nx;
      r_tx_par   <= w_tx_par_nx;
      r_so       <= w_so_nx;
    end
  end

  // Deserializer next state and the push/flag-set events it raises.
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_shift_nx = r_rx_shift;
    w_rx_push     = 1'b0;
    w_par_set     = 1'b0;
    w_frame_set   = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_line == START_BIT) begin
          w_rx_state_nx = RX_DATA;
          w_rx_cnt_nx   = '0;
        end else begin
          w_rx_state_nx = RX_IDLE;
        end
      end
      RX_DATA: begin
        w_rx_shift_nx = {w_rx_line, r_rx_shift[DATA_W-1:1]};
        if (r_rx_cnt == CNT_LAST) begin
          if (PARITY_EN != 0) begin
            w_rx_state_nx = RX_PARITY;
          end else begin
            w_rx_state_nx = RX_STOP;
          end
        end else begin
          w_rx_cnt_nx = r_rx_cnt + 1'b1;
        end
      end
      RX_PARITY: begin
        w_rx_state_nx = RX_STOP;
        w_par_set     = (w_rx_line != even_parity16(w_rx_ext));
      end
      RX_STOP: begin
        w_rx_state_nx = RX_IDLE;
        w_rx_push     = (w_rx_line == STOP_BIT);
        w_frame_set   = (w_rx_line != STOP_BIT);
      end
      default: begin
        w_rx_state_nx = RX_IDLE;
      end
    endcase
  end

  // A completed word is dropped only if the RX FIFO stays full this edge.
  assign w_ovr_set = w_rx_push && w_rx_full && !(READ && !w_rx_empty);

  // Deserializer state register; a frame cut by reset is simply abandoned.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_shift <= w_rx_shift_nx;
    end
  end

  // Sticky error flags; a set event beats clr_err in the same cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rx_overrun <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_ovr_set)        r_rx_overrun <= 1'b1;
      else if (clr_err)     r_rx_overrun <= 1'b0;
      if (w_par_set)        r_parity_err <= 1'b1;
      else if (clr_err)     r_parity_err <= 1'b0;
      if (w_frame_set)      r_frame_err  <= 1'b1;
      else if (clr_err)     r_frame_err  <= 1'b0;
    end
  end

  assign SO         = r_so;
  assign NINTO      = !(w_tx_empty && (r_tx_state == TX_IDLE));
  assign NINTI      = w_rx_empty;
  assign tx_full    = w_tx_full;
  assign rx_overrun = r_rx_overrun;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_usrt_fifo_link.sv
// Directed + randomized bench for usrt_fifo_link. Expected line bits and
// received words come from a frame-level model (bit lists and word queues).
module tb_usrt_fifo_link;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic Reset;

  // Instance A: DATA_W=8, DEPTH=4, PARITY_EN=1
  logic       a_load, a_send, a_read, a_loop, a_si, a_clr;
  logic [7:0] a_tx, a_rx;
  logic       a_so, a_ninto, a_ninti, a_full, a_ovr, a_perr, a_ferr;

  // Instance B: DATA_W=16, DEPTH=2, PARITY_EN=0
  logic        b_load, b_send, b_read, b_loop, b_si, b_clr;
  logic [15:0] b_tx, b_rx;
  logic        b_so, b_ninto, b_ninti, b_full, b_ovr, b_perr, b_ferr;

  usrt_fifo_link #(.DATA_W(8), .DEPTH(4), .PARITY_EN(1)) u_dut_a (
    .Clock(Clock), .Reset(Reset), .load(a_load), .Tx_Data(a_tx), .SEND(a_send),
    .READ(a_read), .LOOP(a_loop), .SI(a_si), .clr_err(a_clr), .SO(a_so),
    .Rx_Data(a_rx), .NINTO(a_ninto), .NINTI(a_ninti), .tx_full(a_full),
    .rx_overrun(a_ovr), .parity_err(a_perr), .frame_err(a_ferr)
  );

  usrt_fifo_link #(.DATA_W(16), .DEPTH(2), .PARITY_EN(0)) u_dut_b (
    .Clock(Clock), .Reset(Reset), .load(b_load), .Tx_Data(b_tx), .SEND(b_send),
    .READ(b_read), .LOOP(b_loop), .SI(b_si), .clr_err(b_clr), .SO(b_so),
    .Rx_Data(b_rx), .NINTO(b_ninto), .NINTI(b_ninti), .tx_full(b_full),
    .rx_overrun(b_ovr), .parity_err(b_perr), .frame_err(b_ferr)
  );

  int checks = 0;
  int failures = 0;

  logic        exp_bits[$];   // expected SO sequence
  logic [15:0] txq[$];        // model of TX FIFO contents
  logic [15:0] rxq[$];        // model of RX FIFO contents
  logic        exp_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clock);
      @(negedge Clock);
    end
  endtask

  // Frame model: start 0, data LSB first, optional even parity, stop 1.
  task automatic add_frame(input logic [15:0] w, input int dw, input bit par);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) exp_bits.push_back(w[i]);
    if (par) exp_bits.push_back(^w);
    exp_bits.push_back(1'b1);
  endtask

  task automatic capture(input bit use_b, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic e;
      e = exp_bits.pop_front();
      chk($sformatf("%s_bit%0d", tag, i), 32'(use_b ? b_so : a_so), 32'(e));
      cyc(1);
    end
  endtask

  // Drain RX FIFO of A, comparing each head with the model queue.
  task automatic read_all_a(input string tag);
    while (rxq.size() > 0) begin
      chk({tag, "_rxdata"}, 32'(a_rx), 32'(rxq.pop_front()));
      a_read = 1'b1;
      cyc(1);
      a_read = 1'b0;
    end
    chk({tag, "_ninti_empty"}, 32'(a_ninti), 32'd1);
    chk({tag, "_rx_zero"}, 32'(a_rx), 32'd0);
  endtask

  // Drive an external frame onto SI of A, one bit per clock.
  task automatic drive_si(input logic [7:0] w, input logic pbit, input logic sbit, input bit clr_at_par);
    a_si = 1'b0;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      a_si = w[i];
      cyc(1);
    end
    a_si = pbit;
    a_clr = clr_at_par;
    cyc(1);
    a_clr = 1'b0;
    a_si = sbit;
    cyc(1);
    a_si = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    int n;
    Reset = 1'b0;
    a_load = 1'b0; a_send = 1'b0; a_read = 1'b0; a_loop = 1'b1; a_si = 1'b1; a_clr = 1'b0; a_tx = '0;
    b_load = 1'b0; b_send = 1'b0; b_read = 1'b0; b_loop = 1'b1; b_si = 1'b1; b_clr = 1'b0; b_tx = '0;
    exp_ovr = 1'b0;
    @(negedge Clock);
    cyc(2);

    // Reset state
    chk("rst_so", 32'(a_so), 32'd1);
    chk("rst_ninto", 32'(a_ninto), 32'd0);
    chk("rst_ninti", 32'(a_ninti), 32'd1);
    chk("rst_txfull", 32'(a_full), 32'd0);
    chk("rst_rxdata", 32'(a_rx), 32'd0);
    chk("rst_flags", 32'({a_ovr, a_perr, a_ferr}), 32'd0);
    chk("rst_b_so", 32'(b_so), 32'd1);
    chk("rst_b_ninto", 32'(b_ninto), 32'd0);
    Reset = 1'b1;
    cyc(2);

    // Loopback single word A5
    a_send = 1'b1; a_load = 1'b1; a_tx = 8'hA5;
    cyc(1);
    a_load = 1'b0;
    chk("a5_ninto_busy", 32'(a_ninto), 32'd1);
    cyc(1);
    add_frame(16'h00A5, 8, 1'b1);
    capture(1'b0, 11, "a5");
    rxq.push_back(16'h00A5);
    chk("a5_ninti", 32'(a_ninti), 32'd0);
    chk("a5_ninto_idle", 32'(a_ninto), 32'd0);
    chk("a5_flags", 32'({a_ovr, a_perr, a_ferr}), 32'd0);
    read_all_a("a5");
    a_read = 1'b1;
    cyc(1);
    a_read = 1'b0;
    chk("read_empty_ignored", 32'(a_ninti), 32'd1);

    // Fill TX FIFO with SEND low; fifth word must be dropped
    a_send = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      a_load = 1'b1; a_tx = 8'(v);
      if (txq.size() < 4) txq.push_back(16'(v));
      cyc(1);
      a_load = 1'b0;
      chk($sformatf("fill_full_%0d", v), 32'(a_full), 32'(txq.size() == 4));
    end
    chk("fill_ninto", 32'(a_ninto), 32'd1);
    a_send = 1'b1;
    cyc(1);
    while (txq.size() > 0) begin
      w = txq.pop_front();
      add_frame(w, 8, 1'b1);
      rxq.push_back(w);
    end
    capture(1'b0, 44, "b2b");
    chk("b2b_ninto", 32'(a_ninto), 32'd0);
    chk("b2b_txfull", 32'(a_full), 32'd0);

    // Fifth frame into a full RX FIFO -> overrun
    a_load = 1'b1; a_tx = 8'h05;
    cyc(1);
    a_load = 1'b0;
    cyc(1);
    add_frame(16'h0005, 8, 1'b1);
    capture(1'b0, 11, "ovr");
    if (rxq.size() >= 4) exp_ovr = 1'b1; else rxq.push_back(16'h0005);
    chk("ovr_flag", 32'(a_ovr), 32'(exp_ovr));
    read_all_a("ovr");
    a_clr = 1'b1;
    cyc(1);
    a_clr = 1'b0;
    chk("ovr_cleared", 32'(a_ovr), 32'd0);

    // SEND dropped mid-frame: current frame completes, next one waits
    a_send = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_load = 1'b1; a_tx = 8'($urandom); txq.push_back(16'(a_tx));
      cyc(1);
    end
    a_load = 1'b0;
    a_send = 1'b1;
    cyc(1);
    a_send = 1'b0;
    w = txq.pop_front();
    add_frame(w, 8, 1'b1);
    rxq.push_back(w);
    capture(1'b0, 11, "hold1");
    for (int i = 0; i < 3; i++) begin
      chk("hold_so_idle", 32'(a_so), 32'd1);
      chk("hold_ninto", 32'(a_ninto), 32'd1);
      cyc(1);
    end
    a_send = 1'b1;
    cyc(1);
    w = txq.pop_front();
    add_frame(w, 8, 1'b1);
    rxq.push_back(w);
    capture(1'b0, 11, "hold2");
    chk("hold_ninto_done", 32'(a_ninto), 32'd0);
    read_all_a("hold");

    // Random batches of back-to-back frames
    for (int b = 0; b < 3; b++) begin
      n = $urandom_range(1, 4);
      a_send = 1'b0;
      for (int i = 0; i < n; i++) begin
        a_load = 1'b1; a_tx = 8'($urandom); txq.push_back(16'(a_tx));
        cyc(1);
      end
      a_load = 1'b0;
      a_send = 1'b1;
      cyc(1);
      while (txq.size() > 0) begin
        w = txq.pop_front();
        add_frame(w, 8, 1'b1);
        rxq.push_back(w);
      end
      capture(1'b0, 11 * n, $sformatf("rnd%0d", b));
      read_all_a($sformatf("rnd%0d", b));
    end

    // External SI: bad parity still stored, bad stop discarded
    a_loop = 1'b0; a_send = 1'b0;
    cyc(2);
    drive_si(8'h3C, ~(^8'h3C), 1'b1, 1'b0);
    rxq.push_back(16'h003C);
    chk("si_par_err", 32'(a_perr), 32'd1);
    chk("si_par_data", 32'(a_rx), 32'h3C);
    chk("si_par_no_ferr", 32'(a_ferr), 32'd0);
    drive_si(8'h5A, ^8'h5A, 1'b0, 1'b0);
    cyc(1);
    chk("si_frame_err", 32'(a_ferr), 32'd1);
    read_all_a("si");
    a_clr = 1'b1;
    cyc(1);
    a_clr = 1'b0;
    chk("si_clr_flags", 32'({a_perr, a_ferr}), 32'd0);
    drive_si(8'h81, ~(^8'h81), 1'b1, 1'b1);
    rxq.push_back(16'h0081);
    chk("set_beats_clr", 32'(a_perr), 32'd1);
    read_all_a("si2");

    // Reset during data bit 3 abandons the frame
    a_loop = 1'b1; a_send = 1'b1; a_load = 1'b1; a_tx = 8'hA5;
    cyc(1);
    a_load = 1'b0;
    cyc(1);
    add_frame(16'h00A5, 8, 1'b1);
    capture(1'b0, 4, "rstmid");
    chk("rstmid_d3", 32'(a_so), 32'(exp_bits.pop_front()));
    exp_bits.delete();
    Reset = 1'b0;
    #1;
    chk("rstmid_so", 32'(a_so), 32'd1);
    chk("rstmid_ninto", 32'(a_ninto), 32'd0);
    chk("rstmid_ninti", 32'(a_ninti), 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    cyc(15);
    chk("rstmid_no_word", 32'(a_ninti), 32'd1);
    chk("rstmid_rx_zero", 32'(a_rx), 32'd0);
    chk("rstmid_so_idle", 32'(a_so), 32'd1);

    // Wide instance: 16-bit words, no parity, depth 2
    b_send = 1'b1; b_load = 1'b1; b_tx = 16'hBEEF;
    cyc(1);
    b_load = 1'b0;
    cyc(1);
    add_frame(16'hBEEF, 16, 1'b0);
    capture(1'b1, 18, "beef");
    chk("beef_rx", 32'(b_rx), 32'hBEEF);
    chk("beef_ninti", 32'(b_ninti), 32'd0);
    b_read = 1'b1;
    cyc(1);
    b_read = 1'b0;
    chk("beef_popped", 32'(b_ninti), 32'd1);
    b_send = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_load = 1'b1; b_tx = 16'($urandom);
      if (txq.size() < 2) txq.push_back(b_tx);
      cyc(1);
    end
    b_load = 1'b0;
    chk("b_full", 32'(b_full), 32'd1);
    b_send = 1'b1;
    cyc(1);
    while (txq.size() > 0) begin
      w = txq.pop_front();
      add_frame(w, 16, 1'b0);
      rxq.push_back(w);
    end
    capture(1'b1, 36, "b_rnd");
    while (rxq.size() > 0) begin
      chk("b_rnd_rx", 32'(b_rx), 32'(rxq.pop_front()));
      b_read = 1'b1;
      cyc(1);
      b_read = 1'b0;
    end
    chk("b_ninto_end", 32'(b_ninto), 32'd0);
    chk("b_flags", 32'({b_ovr, b_perr, b_ferr}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usrt_fifo_link.md
USRT_FIFO_LINK -- requirements
Module: usrt_fifo_link

Interface
REQ-001 The block SHALL have these parameters, one per line:
- DATA_W, 8, serial word width in bits (legal 5..16).
- DEPTH, 4, entries per FIFO (power of two, at least 2).
- PARITY_EN, 1, 1 = even-parity bit inserted and checked; 0 = no parity bit.

REQ-002 The block SHALL have these ports, one per line:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- load  in  1  push Tx_Data into TX FIFO.
- Tx_Data  in  DATA_W  transmit word.
- SEND  in  1  enable draining of the TX FIFO onto the line.
- READ  in  1  pop the RX FIFO.
- LOOP  in  1  1 = receiver input is internal SO; 0 = receiver input is SI.
- SI  in  1  external serial input, idles high.
- clr_err  in  1  clear sticky error flags.
- SO  out  1  serial output, registered, idles high.
- Rx_Data  out  DATA_W  RX FIFO head (first-word fall-through); 0 when empty.
- NINTO  out  1  active-low: TX FIFO empty and serializer idle.
- NINTI  out  1  active-low: RX FIFO not empty.
- tx_full  out  1  TX FIFO full.
- rx_overrun  out  1  sticky: RX word dropped because the RX FIFO was full.
- parity_err  out  1  sticky: a parity mismatch was received.
- frame_err  out  1  sticky: stop bit sampled 0.

Function
REQ-003 Frame SHALL be: start bit 0, DATA_W bits LSB first, parity bit only if PARITY_EN (even: XOR of data bits), stop bit 1; one bit per clock; F = DATA_W+2+PARITY_EN clocks.
REQ-004 load with TX FIFO not full SHALL write Tx_Data at that edge; load when full SHALL be ignored, with no state change.
REQ-005 Serializer states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE -> START on the first edge with SEND=1 and TX FIFO non-empty, popping the head word at that edge.
REQ-006 SO SHALL show the start bit in the cycle after the pop edge; a word loaded into an empty FIFO at edge E0 with SEND=1 and serializer idle SHALL be popped at E1, with start on SO after E1.
REQ-007 After STOP, the serializer SHALL enter START directly if SEND=1 and the FIFO is non-empty (back-to-back frames, no idle bit); otherwise it SHALL return to IDLE.
REQ-008 SEND deasserted mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-009 Deserializer states SHALL be IDLE, DATA, PARITY, STOP; IDLE -> DATA when the receive line samples 0; the next DATA_W edges capture bits LSB first.
REQ-010 On the stop-bit edge: stop=1 and RX FIFO not full SHALL push the word; stop=1 and full SHALL drop the word and set rx_overrun; stop=0 SHALL discard the word and set frame_err.
REQ-011 A parity mismatch SHALL still push the word and set parity_err.
REQ-012 READ with RX FIFO non-empty SHALL pop at that edge; READ when empty SHALL be ignored.
REQ-013 Simultaneous push and pop on a full FIFO SHALL succeed for both; on an empty FIFO only the push SHALL take effect.
REQ-014 Sticky flags SHALL clear on clr_err; a set event in the same cycle as clr_err SHALL win.
REQ-015 FIFO pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty SHALL be decoded from the MSB difference.

Reset
REQ-016 Reset=0 SHALL asynchronously: empty both FIFOs; set both FSMs to IDLE; set SO=1, NINTO=0, NINTI=1, tx_full=0, Rx_Data=0; clear all sticky flags.
REQ-017 Reset asserted mid-frame SHALL abandon the frame; after release, the line idles high and no partial word is pushed.

Structure
REQ-018 Package usrt_pkg SHALL hold the FSM state encodings and the START_BIT and STOP_BIT constants.
REQ-019 A parametrised sub-module usrt_fifo (synchronous, first-word fall-through) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-020 LOOP=1, SEND=1, load 8'hA5 -> SO shows 0,1,0,1,0,0,1,0,1,0(parity),1; Rx_Data=8'hA5 and NINTI=0 one cycle after the stop edge.
REQ-021 SEND=0, load 8'h01..8'h05 -> 4 words accepted, tx_full=1, 8'h05 ignored; raise SEND -> 4 back-to-back frames, NINTO=0 after the last stop.
REQ-022 LOOP=1, 5 frames, no READ -> RX holds 8'h01..8'h04, rx_overrun=1; clr_err -> rx_overrun=0.
REQ-023 LOOP=0, drive SI with 8'h3C and a wrong parity bit -> 8'h3C stored, parity_err=1; next frame with stop=0 -> frame_err=1, not stored.
REQ-024 Reset pulse during data bit 3 -> SO=1 immediately, NINTO=0, NINTI=1; no word appears in the RX FIFO.
REQ-025 DATA_W=16, DEPTH=2, PARITY_EN=0, LOOP=1, load 16'hBEEF -> 18-clock frame; Rx_Data=16'hBEEF.
